// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control logic.
//   RESULT_MEM       : resultSrc encoding that marks a load.
//   FWD_REG/WB/MEM   : ALU operand forwarding selects.
//   hazard_state_t   : hazard unit memory-wait FSM states.
package riscv_pipe_pkg;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-side signals seen by the hazard unit.
//   master : pipeline datapath (drives register fields and memory status,
//            receives forwarding selects, stall/flush controls, counters).
//   slave  : hazard_unit.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  // Register fields and status from the datapath
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [1:0]       resultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM, RdW;
  logic             regWriteM, regWriteW;
  logic             memAccessM, memReadyM;
  // Controls back to the datapath
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushW;
  logic             memError;
  logic [CNT_W-1:0] stallCount, flushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, PCSrcE,
           RdM, RdW, regWriteM, regWriteW, memAccessM, memReadyM,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, memError, stallCount, flushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, PCSrcE,
           RdM, RdW, regWriteM, regWriteW, memAccessM, memReadyM,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, memError, stallCount, flushCount
  );

endinterface

// File: rtl/hazard_unit_forward_sel.sv
// Forwarding select for one ALU operand in EX.
//   RsE                  : source register of the operand.
//   RdM, regWriteM       : destination / write enable in MEM.
//   RdW, regWriteW       : destination / write enable in WB.
//   forward              : FWD_MEM, FWD_WB or FWD_REG.
// MEM wins over WB because it holds the younger result; x0 is never forwarded.
module forward_sel
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] forward
);

  always_comb begin
    if (regWriteM && (RdM != 5'd0) && (RdM == RsE))
      forward = FWD_MEM;
    else if (regWriteW && (RdW != 5'd0) && (RdW == RsE))
      forward = FWD_WB;
    else
      forward = FWD_REG;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//   clk, rst : clock and synchronous active-high reset.
//   hz       : hazard_unit_if slave port (register fields, memory status in;
//              forwarding selects, stall/flush controls, memError and the
//              saturating stall/flush counters out).
// Stall and flush outputs are combinational from inputs and FSM state. A data
// memory access that stays not-ready freezes the pipeline; after MEM_TIMEOUT
// consecutive not-ready cycles the unit locks in ERROR until reset.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst,
  hazard_unit_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t     state;
  // Number of not-ready cycles already completed in the current wait.
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;
  logic              timeoutHit;
  logic              memErrorQ;
  logic [CNT_W-1:0]  stallCountQ, flushCountQ;

  logic [1:0] fwdA, fwdB;
  logic       lwStall, memStall;
  logic       frozen, branchFlush, loadStall;

  forward_sel u_fwd_a (
    .RsE       (hz.Rs1E),
    .RdM       (hz.RdM),
    .RdW       (hz.RdW),
    .regWriteM (hz.regWriteM),
    .regWriteW (hz.regWriteW),
    .forward   (fwdA)
  );

  forward_sel u_fwd_b (
    .RsE       (hz.Rs2E),
    .RdM       (hz.RdM),
    .RdW       (hz.RdW),
    .regWriteM (hz.regWriteM),
    .regWriteW (hz.regWriteW),
    .forward   (fwdB)
  );

  assign lwStall  = (hz.resultSrcE == RESULT_MEM) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign memStall = hz.memAccessM && !hz.memReadyM;

  // Pipeline frozen on a not-ready memory cycle or in ERROR. The release
  // cycle of a wait is not frozen, so a branch held in EX is flushed then.
  assign frozen = (state == ERROR) ||
                  ((state == RUN) && memStall) ||
                  ((state == MEM_WAIT) && !hz.memReadyM);

  // Branch flush outranks the load-use stall: the load's consumer is squashed.
  assign branchFlush = !frozen && hz.PCSrcE;
  assign loadStall   = !frozen && !hz.PCSrcE && lwStall;

  // Count including the current not-ready cycle; waitCnt is 0 in RUN.
  assign waitNext   = waitCnt + WAIT_W'(1);
  assign timeoutHit = (waitNext == WAIT_W'(MEM_TIMEOUT));

  assign hz.forwardAE = rst ? FWD_REG : fwdA;
  assign hz.forwardBE = rst ? FWD_REG : fwdB;
  assign hz.stallF    = !rst && (frozen || loadStall);
  assign hz.stallD    = !rst && (frozen || loadStall);
  assign hz.stallE    = !rst && frozen;
  assign hz.stallM    = !rst && frozen;
  assign hz.flushD    = rst || branchFlush;
  assign hz.flushE    = rst || branchFlush || loadStall;
  assign hz.flushW    = rst || frozen;

  assign hz.memError   = memErrorQ;
  assign hz.stallCount = stallCountQ;
  assign hz.flushCount = flushCountQ;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      memErrorQ   <= 1'b0;
      stallCountQ <= '0;
      flushCountQ <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            if (timeoutHit) begin
              state     <= ERROR;
              memErrorQ <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
            waitCnt <= waitNext;
          end
        end
        MEM_WAIT: begin
          if (hz.memReadyM) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (timeoutHit) begin
            state     <= ERROR;
            memErrorQ <= 1'b1;
            waitCnt   <= waitNext;
          end else begin
            waitCnt <= waitNext;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase

      if (hz.stallF && (stallCountQ != '1))
        stallCountQ <= stallCountQ + CNT_W'(1);
      if (branchFlush && (flushCountQ != '1))
        flushCountQ <= flushCountQ + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit (MEM_TIMEOUT=4, CNT_W=4).
// The driver applies one vector per cycle and queues its expected outputs;
// the monitor pops one entry each negedge and compares.
module tb_hazard_unit;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, se, sm;
    logic       fd, fe, fw;
    logic       me;
    logic [3:0] sc, fc;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  sb_t  sb[$];

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(4)) hif ();

  hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic se,
                              input logic sm, input logic fd, input logic fe,
                              input logic fw, input logic me,
                              input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e = '{fa, fb, sf, sd, se, sm, fd, fe, fw, me, sc, fc};
    return e;
  endfunction

  task automatic idle_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    hif.Rs1E = 5'd0; hif.Rs2E = 5'd0; hif.RdE = 5'd0;
    hif.resultSrcE = 2'b00; hif.PCSrcE = 1'b0;
    hif.RdM = 5'd0; hif.RdW = 5'd0;
    hif.regWriteM = 1'b0; hif.regWriteW = 1'b0;
    hif.memAccessM = 1'b0; hif.memReadyM = 1'b0;
  endtask

  // Queue the expectation for the vector currently applied, then advance.
  task automatic cyc(input string name, input exp_t e);
    sb_t item;
    item.name = name;
    item.e    = e;
    sb.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fa=%b fb=%b stFDEM=%b%b%b%b flDEW=%b%b%b err=%b sc=%0d fc=%0d, want fa=%b fb=%b stFDEM=%b%b%b%b flDEW=%b%b%b err=%b sc=%0d fc=%0d",
               name, act.fa, act.fb, act.sf, act.sd, act.se, act.sm,
               act.fd, act.fe, act.fw, act.me, act.sc, act.fc,
               exp.fa, exp.fb, exp.sf, exp.sd, exp.se, exp.sm,
               exp.fd, exp.fe, exp.fw, exp.me, exp.sc, exp.fc);
    end
  endtask

  // Monitor
  initial begin
    sb_t  item;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        act  = '{hif.forwardAE, hif.forwardBE,
                 hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                 hif.flushD, hif.flushE, hif.flushW, hif.memError,
                 hif.stallCount, hif.flushCount};
        check(item.name, act, item.e);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset cycle forces forward=00, no stall, all flushes high.
    hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.regWriteM = 1'b1;
    cyc("reset_outputs", ex(2'b00,2'b00, 0,0,0,0, 1,1,1, 0, 4'd0,4'd0));
    rst = 1'b0;

    // Forwarding
    hif.Rs1E = 5'd5; hif.Rs2E = 5'd6; hif.RdM = 5'd5; hif.regWriteM = 1'b1;
    hif.RdW = 5'd5; hif.regWriteW = 1'b1;
    cyc("fwd_mem_priority", ex(2'b10,2'b00, 0,0,0,0, 0,0,0, 0, 4'd0,4'd0));
    hif.RdM = 5'd0;
    cyc("fwd_wb_rdm_x0", ex(2'b01,2'b00, 0,0,0,0, 0,0,0, 0, 4'd0,4'd0));
    hif.Rs1E = 5'd0; hif.RdW = 5'd0; hif.Rs2E = 5'd9;
    cyc("fwd_x0_never", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd0,4'd0));
    hif.regWriteM = 1'b0; hif.RdM = 5'd6; hif.RdW = 5'd6;
    hif.Rs1E = 5'd6; hif.Rs2E = 5'd6;
    cyc("fwd_wb_mem_nowrite", ex(2'b01,2'b01, 0,0,0,0, 0,0,0, 0, 4'd0,4'd0));
    hif.regWriteM = 1'b1;
    cyc("fwd_mem_both", ex(2'b10,2'b10, 0,0,0,0, 0,0,0, 0, 4'd0,4'd0));

    // Load-use stall
    idle_inputs();
    hif.resultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    cyc("lw_stall", ex(2'b00,2'b00, 1,1,0,0, 0,1,0, 0, 4'd0,4'd0));
    idle_inputs();
    cyc("lw_release", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd1,4'd0));
    hif.resultSrcE = 2'b01; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
    cyc("lw_rd_x0", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd1,4'd0));
    hif.resultSrcE = 2'b00; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
    cyc("non_load", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd1,4'd0));

    // Branch flush beats load-use stall
    hif.resultSrcE = 2'b01; hif.PCSrcE = 1'b1;
    cyc("branch_over_lw", ex(2'b00,2'b00, 0,0,0,0, 1,1,0, 0, 4'd1,4'd0));
    idle_inputs();
    cyc("flush_counted", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd1,4'd1));

    // Memory wait of 3 not-ready cycles with a branch held in EX
    hif.memAccessM = 1'b1; hif.memReadyM = 1'b0; hif.PCSrcE = 1'b1;
    cyc("wait_1", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd1,4'd1));
    cyc("wait_2", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd2,4'd1));
    cyc("wait_3", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd3,4'd1));
    hif.memReadyM = 1'b1;
    cyc("wait_release", ex(2'b00,2'b00, 0,0,0,0, 1,1,0, 0, 4'd4,4'd1));
    idle_inputs();
    cyc("after_wait", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd4,4'd2));

    // Ready on the first access cycle: no stall, no state change
    hif.memAccessM = 1'b1; hif.memReadyM = 1'b1;
    cyc("ready_first", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd4,4'd2));
    idle_inputs();
    cyc("still_run", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd4,4'd2));

    // Timeout after 4 not-ready cycles
    hif.memAccessM = 1'b1; hif.memReadyM = 1'b0;
    cyc("to_wait_1", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd4,4'd2));
    cyc("to_wait_2", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd5,4'd2));
    cyc("to_wait_3", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd6,4'd2));
    cyc("to_wait_4", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd7,4'd2));
    // ERROR stays frozen even when memory turns ready and a branch arrives.
    hif.memAccessM = 1'b0; hif.memReadyM = 1'b1; hif.PCSrcE = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cyc($sformatf("error_frozen_%0d", k),
          ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 1,
             (8 + k > 15) ? 4'd15 : 4'(8 + k), 4'd2));
    end

    // Reset out of ERROR
    rst = 1'b1;
    hif.memAccessM = 1'b1; hif.memReadyM = 1'b0; hif.PCSrcE = 1'b0;
    cyc("reset_in_error", ex(2'b00,2'b00, 0,0,0,0, 1,1,1, 1, 4'd15,4'd2));
    rst = 1'b0;
    cyc("run_after_reset", ex(2'b00,2'b00, 1,1,1,1, 0,0,1, 0, 4'd0,4'd0));
    hif.memReadyM = 1'b1;
    cyc("release_after_reset", ex(2'b00,2'b00, 0,0,0,0, 0,0,0, 0, 4'd1,4'd0));

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard and forwarding controller for the 5-stage RISC-V pipeline. It consumes the EX-side outputs of the ID/EX register (Rs1E, Rs2E, RdE, resultSrcE) and the EX/MEM and MEM/WB destination fields. It drives forwarding selects plus the stall and flush controls of every pipeline register, including the ID/EX clear. It adds a data-memory wait FSM with timeout, and saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive not-ready cycles for a MEM-stage access before the unit enters error.
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in ID.
- Rs1E, Rs2E, RdE  in  5 each  register fields from ID/EX.
- resultSrcE  in  2  result select in EX; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- RdM, RdW  in  5 each  destination in MEM, WB.
- regWriteM, regWriteW  in  1 each  register-write enables in MEM, WB.
- memAccessM  in  1  a load or store is in MEM.
- memReadyM  in  1  data memory completes the access this cycle.
- forwardAE, forwardBE  out  2 each  ALU operand select: 00 = register file, 10 = ALUResultM, 01 = resultW.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC, IF/ID, ID/EX, EX/MEM registers.
- flushD, flushE, flushW  out  1 each  clear IF/ID, ID/EX, MEM/WB.
- memError  out  1  sticky timeout flag.
- stallCount, flushCount  out  CNT_W each  performance counters.

## Operation
- **Forwarding (combinational, per operand, shown for A):**
  - 10 if regWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if regWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00.
  - MEM has priority over WB. x0 is never forwarded.
- **lwStall** = (resultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- **memStall** = memAccessM && !memReadyM.
- **FSM states:** RUN, MEM_WAIT, ERROR.
- **RUN:**
  - If memStall:
    - Assert stallF/D/E/M and flushW. Deassert flushD/flushE.
    - Go to MEM_WAIT. waitCnt←1.
  - Else if PCSrcE: flushD=flushE=1.
  - Else if lwStall: stallF=stallD=1, flushE=1.
  - Priority is memStall > PCSrcE > lwStall. When PCSrcE and lwStall coincide, the flush wins and no stall is raised.
- **MEM_WAIT:**
  - Same outputs as the memStall case in RUN. waitCnt increments.
  - On memReadyM: outputs are evaluated as in RUN with memStall=0, and next state is RUN. A branch held in EX is flushed on this cycle.
  - If waitCnt==MEM_TIMEOUT and !memReadyM: go to ERROR and set memError.
- **ERROR:**
  - stallF/D/E/M=1, flushW=1, flushD=flushE=0.
  - Exit only by rst.
- **Counters:**
  - stallCount increments every cycle stallF=1.
  - flushCount increments every cycle the PCSrcE flush is applied.
  - Both saturate at all-ones and never wrap.
- **Reset (rst high):**
  - State←RUN, waitCnt←0, memError←0, counters←0.
  - During the rst cycle, outputs are forced to: forward 00, all stalls 0, flushD=flushE=flushW=1.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and current state, and are valid in the same cycle.
- Load-use stall lasts exactly one cycle, because the load then advances to MEM.
- Memory wait of N not-ready cycles produces N stall cycles. The release cycle is not stalled.
- Timeout: ERROR is entered at the posedge after MEM_TIMEOUT consecutive not-ready cycles. memError is high from that edge.
- rst is sampled synchronously. Asserting rst mid-wait or in ERROR returns the unit to RUN at the next edge.
- memReadyM arriving on the same cycle memAccessM first rises gives no stall and no state change.

## Structure
- Shared package riscv_pipe_pkg holds:
  - RESULT_MEM=2'b01.
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State encodings RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2.
- One sub-module, forward_sel: takes RsE, RdM, RdW, regWriteM and regWriteW, and returns a 2-bit select. It is instantiated twice.
- FSM, waitCnt and counters are inline.

## Test plan
- Rs1E=5, RdM=5, regWriteM=1, RdW=5, regWriteW=1 -> forwardAE=10. With RdM=0 instead -> forwardAE=01. With Rs1E=0 -> forwardAE=00.
- Load in EX (resultSrcE=01, RdE=7), Rs2D=7 -> one cycle of stallF=stallD=flushE=1, then released; stallCount=1.
- PCSrcE=1 together with lwStall -> flushD=flushE=1, stallF=0; flushCount increments by 1.
- memAccessM=1, memReadyM low for 3 cycles then high -> stallF/D/E/M and flushW high for exactly 3 cycles. A PCSrcE held during the wait is flushed on the release cycle.
- memReadyM held low with MEM_TIMEOUT=4 -> ERROR entered after 4 cycles, memError=1, and the pipeline stays frozen. rst then clears memError, returns to RUN and zeroes the counters.
- Force stallCount near all-ones by a long wait with small CNT_W=4 -> the counter holds at 15.
